// File: rtl/tlb_pkg.sv
// tlb_pkg: shared definitions for the TLB instruction sequencer.
//   - op_code values carried from the EX stage
//   - INVTLB op field values and the clear_mem encoding handed to the TLB
//   - sequencer state encoding
package tlb_pkg;

  localparam logic [2:0] TLBOP_SRCH = 3'd0;
  localparam logic [2:0] TLBOP_RD   = 3'd1;
  localparam logic [2:0] TLBOP_WR   = 3'd2;
  localparam logic [2:0] TLBOP_FILL = 3'd3;
  localparam logic [2:0] TLBOP_INV  = 3'd4;

  typedef enum logic [4:0] {
    INV_ALL        = 5'd0,
    INV_ALL_ALT    = 5'd1,
    INV_G1         = 5'd2,
    INV_G0         = 5'd3,
    INV_G0_ASID    = 5'd4,
    INV_G0_ASID_VA = 5'd5,
    INV_GA_ASID_VA = 5'd6
  } inv_op_e;

  typedef enum logic [2:0] {
    CLR_NONE       = 3'd0,
    CLR_ALL        = 3'd1,
    CLR_G1         = 3'd2,
    CLR_G0         = 3'd3,
    CLR_G0_ASID    = 3'd4,
    CLR_G0_ASID_VA = 3'd5,
    CLR_GA_ASID_VA = 3'd6
  } clear_mem_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic inv_op_bad(input logic [4:0] op);
    return op > 5'd6;
  endfunction

  // INVTLB ops 0 and 1 both clear everything, so both map to code 1;
  // code 0 is reserved on the TLB side for "no clear this cycle".
  function automatic clear_mem_e clear_code(input logic [4:0] op);
    clear_mem_e c;
    case (op)
      INV_ALL, INV_ALL_ALT: c = CLR_ALL;
      INV_G1:               c = CLR_G1;
      INV_G0:               c = CLR_G0;
      INV_G0_ASID:          c = CLR_G0_ASID;
      INV_G0_ASID_VA:       c = CLR_G0_ASID_VA;
      INV_GA_ASID_VA:       c = CLR_GA_ASID_VA;
      default:              c = CLR_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tlb_op_ctrl_fill_counter.sv
// tlb_fill_counter: free-running wrap-around entry index used by TLBFILL.
//   clk   in   system clock
//   rstn  in   asynchronous active-low reset (counter returns to 0)
//   cnt   out  current fill index, advances every cycle, wraps at 2**IDXW
module tlb_fill_counter #(
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [IDXW-1:0] cnt
);

  logic [IDXW-1:0] cnt_q;
  logic [IDXW-1:0] cnt_d;

  // Entry count is a power of two, so natural overflow is the wrap.
  always_comb cnt_d = cnt_q + IDXW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: accepts one TLB instruction per handshake, drives the TLB
// ports for exactly one cycle, then returns a one-cycle completion beat.
//   op_valid/op_ready/op_code + operands : request from EX stage
//   flush                                : blocks acceptance only
//   done_*                               : completion beat to CSR/writeback
//   tlb_*  (out)                         : TLB read/search/write/fill/clear
//   tlb_rs_e, tlb_s_index (in)           : TLB search/read return
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a request (unless flush)
// ST_EXEC | TLB strobes/operands valid; TLB return sampled at cycle end
// ST_RESP | done_valid high with latched results, TLB strobes low
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [31:0]     inv_vaddr,
  input  logic [IDXW-1:0] csr_index,
  input  logic [18:0]     csr_vpn2,
  input  logic            flush,
  output logic            done_valid,
  output logic [2:0]      done_op,
  output logic            done_err,
  output logic            done_hit,
  output logic [IDXW-1:0] done_index,
  output logic            tlb_we,
  output logic            tlb_fill_mode,
  output logic [IDXW-1:0] tlb_w_index,
  output logic [IDXW-1:0] tlb_f_index,
  output logic [IDXW-1:0] tlb_r_index,
  output logic            tlb_check_mode,
  output logic [18:0]     tlb_s_vpn2,
  input  logic            tlb_rs_e,
  input  logic [IDXW-1:0] tlb_s_index,
  output logic [2:0]      tlb_clear_mem,
  output logic [31:0]     tlb_clear_vaddr,
  output logic [9:0]      tlb_clear_asid
);

  logic [IDXW-1:0] fill_cnt;

  tlb_fill_counter #(.IDXW(IDXW)) u_fill_cnt (
    .clk  (clk),
    .rstn (rstn),
    .cnt  (fill_cnt)
  );

  state_e          state_q, state_d;
  logic [2:0]      op_code_q, op_code_d;
  logic            err_q, err_d;
  logic [IDXW-1:0] fidx_q, fidx_d;

  logic            done_valid_q, done_valid_d;
  logic [2:0]      done_op_q, done_op_d;
  logic            done_err_q, done_err_d;
  logic            done_hit_q, done_hit_d;
  logic [IDXW-1:0] done_index_q, done_index_d;

  logic            we_q, we_d;
  logic            fill_mode_q, fill_mode_d;
  logic [IDXW-1:0] w_index_q, w_index_d;
  logic [IDXW-1:0] f_index_q, f_index_d;
  logic [IDXW-1:0] r_index_q, r_index_d;
  logic            check_mode_q, check_mode_d;
  logic [18:0]     s_vpn2_q, s_vpn2_d;
  logic [2:0]      clear_mem_q, clear_mem_d;
  logic [31:0]     clear_vaddr_q, clear_vaddr_d;
  logic [9:0]      clear_asid_q, clear_asid_d;

  assign op_ready = (state_q == ST_IDLE) && !flush;

  always_comb begin
    state_d       = state_q;
    op_code_d     = op_code_q;
    err_d         = err_q;
    fidx_d        = fidx_q;
    done_valid_d  = 1'b0;
    done_op_d     = '0;
    done_err_d    = 1'b0;
    done_hit_d    = 1'b0;
    done_index_d  = '0;
    we_d          = 1'b0;
    fill_mode_d   = 1'b0;
    w_index_d     = '0;
    f_index_d     = '0;
    r_index_d     = '0;
    check_mode_d  = 1'b0;
    s_vpn2_d      = '0;
    clear_mem_d   = '0;
    clear_vaddr_d = '0;
    clear_asid_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid && op_ready) begin
          state_d   = ST_EXEC;
          op_code_d = op_code;
          fidx_d    = fill_cnt;
          err_d     = (op_code > TLBOP_INV) ||
                      ((op_code == TLBOP_INV) && inv_op_bad(inv_op));
          // TLB strobes are registered here so they appear for the whole
          // EXEC cycle and fall with the async reset if it hits.
          case (op_code)
            TLBOP_SRCH: begin
              check_mode_d = 1'b1;
              s_vpn2_d     = csr_vpn2;
            end
            TLBOP_RD: r_index_d = csr_index;
            TLBOP_WR: begin
              we_d      = 1'b1;
              w_index_d = csr_index;
            end
            TLBOP_FILL: begin
              we_d        = 1'b1;
              fill_mode_d = 1'b1;
              f_index_d   = fill_cnt;
            end
            TLBOP_INV: begin
              if (!inv_op_bad(inv_op)) begin
                clear_mem_d   = clear_code(inv_op);
                clear_vaddr_d = inv_vaddr;
                clear_asid_d  = inv_asid;
              end
            end
            default: ;
          endcase
        end
      end
      ST_EXEC: begin
        state_d      = ST_RESP;
        done_valid_d = 1'b1;
        done_op_d    = op_code_q;
        done_err_d   = err_q;
        case (op_code_q)
          TLBOP_SRCH: begin
            done_hit_d   = tlb_rs_e;
            done_index_d = tlb_rs_e ? tlb_s_index : '0;
          end
          TLBOP_RD:   done_hit_d   = tlb_rs_e;
          TLBOP_FILL: done_index_d = fidx_q;
          default: ;
        endcase
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      op_code_q     <= '0;
      err_q         <= 1'b0;
      fidx_q        <= '0;
      done_valid_q  <= 1'b0;
      done_op_q     <= '0;
      done_err_q    <= 1'b0;
      done_hit_q    <= 1'b0;
      done_index_q  <= '0;
      we_q          <= 1'b0;
      fill_mode_q   <= 1'b0;
      w_index_q     <= '0;
      f_index_q     <= '0;
      r_index_q     <= '0;
      check_mode_q  <= 1'b0;
      s_vpn2_q      <= '0;
      clear_mem_q   <= '0;
      clear_vaddr_q <= '0;
      clear_asid_q  <= '0;
    end else begin
      state_q       <= state_d;
      op_code_q     <= op_code_d;
      err_q         <= err_d;
      fidx_q        <= fidx_d;
      done_valid_q  <= done_valid_d;
      done_op_q     <= done_op_d;
      done_err_q    <= done_err_d;
      done_hit_q    <= done_hit_d;
      done_index_q  <= done_index_d;
      we_q          <= we_d;
      fill_mode_q   <= fill_mode_d;
      w_index_q     <= w_index_d;
      f_index_q     <= f_index_d;
      r_index_q     <= r_index_d;
      check_mode_q  <= check_mode_d;
      s_vpn2_q      <= s_vpn2_d;
      clear_mem_q   <= clear_mem_d;
      clear_vaddr_q <= clear_vaddr_d;
      clear_asid_q  <= clear_asid_d;
    end
  end

  assign done_valid      = done_valid_q;
  assign done_op         = done_op_q;
  assign done_err        = done_err_q;
  assign done_hit        = done_hit_q;
  assign done_index      = done_index_q;
  assign tlb_we          = we_q;
  assign tlb_fill_mode   = fill_mode_q;
  assign tlb_w_index     = w_index_q;
  assign tlb_f_index     = f_index_q;
  assign tlb_r_index     = r_index_q;
  assign tlb_check_mode  = check_mode_q;
  assign tlb_s_vpn2      = s_vpn2_q;
  assign tlb_clear_mem   = clear_mem_q;
  assign tlb_clear_vaddr = clear_vaddr_q;
  assign tlb_clear_asid  = clear_asid_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
module tb_tlb_op_ctrl;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic            clk, rstn;
  logic            op_valid, op_ready;
  logic [2:0]      op_code;
  logic [4:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [31:0]     inv_vaddr;
  logic [IDXW-1:0] csr_index;
  logic [18:0]     csr_vpn2;
  logic            flush;
  logic            done_valid, done_err, done_hit;
  logic [2:0]      done_op;
  logic [IDXW-1:0] done_index;
  logic            tlb_we, tlb_fill_mode, tlb_check_mode, tlb_rs_e;
  logic [IDXW-1:0] tlb_w_index, tlb_f_index, tlb_r_index, tlb_s_index;
  logic [18:0]     tlb_s_vpn2;
  logic [2:0]      tlb_clear_mem;
  logic [31:0]     tlb_clear_vaddr;
  logic [9:0]      tlb_clear_asid;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .rstn(rstn), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vaddr(inv_vaddr),
    .csr_index(csr_index), .csr_vpn2(csr_vpn2), .flush(flush),
    .done_valid(done_valid), .done_op(done_op), .done_err(done_err),
    .done_hit(done_hit), .done_index(done_index),
    .tlb_we(tlb_we), .tlb_fill_mode(tlb_fill_mode), .tlb_w_index(tlb_w_index),
    .tlb_f_index(tlb_f_index), .tlb_r_index(tlb_r_index),
    .tlb_check_mode(tlb_check_mode), .tlb_s_vpn2(tlb_s_vpn2),
    .tlb_rs_e(tlb_rs_e), .tlb_s_index(tlb_s_index),
    .tlb_clear_mem(tlb_clear_mem), .tlb_clear_vaddr(tlb_clear_vaddr),
    .tlb_clear_asid(tlb_clear_asid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: an op accepted at edge h executes in the cycle after
  // edge h, reports in the cycle after edge h+1, and the next op can be
  // accepted no earlier than edge h+3. Fill index at edge n is n mod TLBNUM,
  // counting edges since reset release.
  int          nedge, last, h;
  logic [2:0]  m_op;
  logic [4:0]  m_inv;
  logic [9:0]  m_asid;
  logic [31:0] m_vaddr;
  logic [3:0]  m_idx;
  logic [18:0] m_vpn2;
  int          m_fidx;
  logic        m_rs_e;
  logic [3:0]  m_sidx;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nedge <= 0;
      last  <= -1;
      h     <= -100;
    end else begin
      if ((nedge - h >= 3) && op_valid && !flush) begin
        h       <= nedge;
        m_op    <= op_code;
        m_inv   <= inv_op;
        m_asid  <= inv_asid;
        m_vaddr <= inv_vaddr;
        m_idx   <= csr_index;
        m_vpn2  <= csr_vpn2;
        m_fidx  <= nedge % TLBNUM;
      end else if (nedge - h == 1) begin
        m_rs_e <= tlb_rs_e;
        m_sidx <= tlb_s_index;
      end
      last  <= nedge;
      nedge <= nedge + 1;
    end
  end

  always @(negedge clk) begin : cmp
    int d;
    bit ex, rs, inv_ok;
    logic [2:0] e_clr;
    if (run) begin
      d      = last - h;
      ex     = (d == 0);
      rs     = (d == 1);
      inv_ok = (m_op == 3'd4) && (m_inv <= 5'd6);
      e_clr  = !inv_ok ? 3'd0 : (m_inv == 5'd0 ? 3'd1 : m_inv[2:0]);
      chk("op_ready", op_ready, (d >= 2) && !flush);
      chk("tlb_we", tlb_we, ex && (m_op == 3'd2 || m_op == 3'd3));
      chk("tlb_fill_mode", tlb_fill_mode, ex && m_op == 3'd3);
      chk("tlb_w_index", tlb_w_index, (ex && m_op == 3'd2) ? m_idx : 4'd0);
      chk("tlb_f_index", tlb_f_index, (ex && m_op == 3'd3) ? m_fidx : 0);
      chk("tlb_r_index", tlb_r_index, (ex && m_op == 3'd1) ? m_idx : 4'd0);
      chk("tlb_check_mode", tlb_check_mode, ex && m_op == 3'd0);
      chk("tlb_s_vpn2", tlb_s_vpn2, (ex && m_op == 3'd0) ? m_vpn2 : 19'd0);
      chk("tlb_clear_mem", tlb_clear_mem, ex ? e_clr : 3'd0);
      chk("tlb_clear_vaddr", tlb_clear_vaddr, (ex && inv_ok) ? m_vaddr : 32'd0);
      chk("tlb_clear_asid", tlb_clear_asid, (ex && inv_ok) ? m_asid : 10'd0);
      chk("done_valid", done_valid, rs);
      chk("done_op", done_op, rs ? m_op : 3'd0);
      chk("done_err", done_err, rs && (m_op > 3'd4 || (m_op == 3'd4 && m_inv > 5'd6)));
      chk("done_hit", done_hit, rs && (m_op == 3'd0 || m_op == 3'd1) && m_rs_e);
      chk("done_index", done_index,
          !rs ? 0 : (m_op == 3'd0 ? (m_rs_e ? m_sidx : 4'd0) : (m_op == 3'd3 ? m_fidx : 0)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after a rising edge; returns 1ns after the accepting edge.
  task automatic send(input logic [2:0] oc);
    bit ok, rdy;
    ok = 1'b0;
    op_code  = oc;
    op_valid = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      rdy = op_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    op_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL handshake_timeout: got no accept expected accept within 8 cycles");
    end
  endtask

  initial begin
    op_valid = 0; op_code = 0; inv_op = 0; inv_asid = 0; inv_vaddr = 0;
    csr_index = 0; csr_vpn2 = 0; flush = 0; tlb_rs_e = 0; tlb_s_index = 0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1 run = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_op_ready", op_ready, 1);
    chk("rst_we", tlb_we, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_clear_mem", tlb_clear_mem, 0);
    chk("rst_check_mode", tlb_check_mode, 0);
    rstn = 1'b1;

    // FILL accepted at the edge where the counter holds 5
    repeat (5) step();
    send(3'd3);
    chk("fill_we", tlb_we, 1);
    chk("fill_mode", tlb_fill_mode, 1);
    chk("fill_f_index", tlb_f_index, 5);
    step();
    chk("fill_done_valid", done_valid, 1);
    chk("fill_done_index", done_index, 5);
    step();

    // SRCH hit then miss
    csr_vpn2 = 19'h1234; tlb_rs_e = 1; tlb_s_index = 4'd3;
    send(3'd0);
    chk("srch_vpn2", tlb_s_vpn2, 32'h1234);
    step();
    chk("srch_hit", done_hit, 1);
    chk("srch_index", done_index, 3);
    step();
    tlb_rs_e = 0;
    send(3'd0);
    step();
    chk("miss_hit", done_hit, 0);
    chk("miss_index", done_index, 0);
    step();

    // RD returns E bit
    csr_index = 4'd7; tlb_rs_e = 1;
    send(3'd1);
    chk("rd_r_index", tlb_r_index, 7);
    step();
    chk("rd_hit", done_hit, 1);
    step();
    tlb_rs_e = 0;

    // WR: single strobe
    csr_index = 4'd15;
    send(3'd2);
    chk("wr_we", tlb_we, 1);
    chk("wr_w_index", tlb_w_index, 15);
    chk("wr_fill_mode", tlb_fill_mode, 0);
    step();
    chk("wr_we_resp", tlb_we, 0);
    step();
    chk("wr_we_after", tlb_we, 0);

    // INVTLB variants, bad op, reserved op_code
    inv_asid = 10'h155; inv_vaddr = 32'hDEADB000; inv_op = 5'd0;
    send(3'd4);
    chk("inv0_clear", tlb_clear_mem, 1);
    chk("inv0_asid", tlb_clear_asid, 32'h155);
    step(); step();
    inv_op = 5'd5;
    send(3'd4);
    chk("inv5_clear", tlb_clear_mem, 5);
    chk("inv5_vaddr", tlb_clear_vaddr, 32'hDEADB000);
    step(); step();
    inv_op = 5'd9;
    send(3'd4);
    chk("inv9_clear", tlb_clear_mem, 0);
    step();
    chk("inv9_err", done_err, 1);
    step();
    inv_op = 5'd0;
    send(3'd6);
    chk("rsv_we", tlb_we, 0);
    step();
    chk("rsv_err", done_err, 1);
    chk("rsv_op", done_op, 6);
    step();

    // flush blocks acceptance, but not an op already in EXEC
    op_code = 3'd2; csr_index = 4'd2; flush = 1; op_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_ready", op_ready, 0);
    end
    step();
    op_valid = 0; flush = 0;
    chk("flush_no_exec", tlb_we, 0);
    send(3'd2);
    flush = 1;
    step();
    chk("flush_exec_done", done_valid, 1);
    flush = 0;
    step();

    // async reset during WR EXEC
    csr_index = 4'd9;
    send(3'd2);
    chk("arst_we_before", tlb_we, 1);
    #3 rstn = 1'b0;
    #1;
    chk("arst_we", tlb_we, 0);
    chk("arst_ready", op_ready, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("arst_done", done_valid, 0);
    end
    @(negedge clk); #1 rstn = 1'b1;
    repeat (15) step();
    send(3'd3);
    chk("wrap_f15", tlb_f_index, 15);
    step();
    chk("wrap_done15", done_index, 15);
    step();
    send(3'd3);
    chk("wrap_f2", tlb_f_index, 2);
    step();
    chk("wrap_done2", done_index, 2);
    repeat (3) step();

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
